fft_run_sequencer: RTL and testbench
====================================

Name: fft_run_sequencer

Overview:
- Single-clock controller that sequences the phase-extraction datapath.
- Captures blocks of 2^FFT_DEPTH antenna samples into the FFT input buffer and kicks the FFT core.
- Waits for FFT completion, then repeats for RUNS runs and reports completion.
- Sits between the sample-strobe source (20.48 MHz sample domain, already synchronised into clk) and the FFT/buffer datapath.

Parameters:
- SINK_WIDTH, 14, bits per antenna sample.
- FFT_DEPTH, 11, FFT levels; block length N = 2^FFT_DEPTH samples.
- RUNS, 3, FFT runs per start command (≥1).
- FFT_TIMEOUT, 65536, max clk cycles in FFT_WAIT (used only with FFT_TIMEOUT_EN).

Ports:
- clk  in  1  main clock (50 MHz).
- reset_n  in  1  synchronous active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  cancel sequence; returns to IDLE.
- sample_valid  in  1  one-cycle strobe per new sample.
- sink  in  SINK_WIDTH  antenna sample, valid with sample_valid.
- wr_en  out  1  buffer write enable.
- wr_addr  out  FFT_DEPTH  buffer write address.
- wr_data  out  SINK_WIDTH  buffer write data.
- fft_start  out  1  one-cycle FFT kick.
- fft_done  in  1  FFT finished (pulse or level).
- run_idx  out  $clog2(RUNS+1)  index of current run, 0-based.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after last run.
- sample_drop  out  1  sticky: sample_valid arrived outside CAPTURE while busy.
- timeout_err  out  1  sticky: FFT timeout (FFT_TIMEOUT_EN only; else tied 0).

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, and all outputs/counters 0, including both sticky flags.
- States: IDLE, CAPTURE, KICK, FFT_WAIT, NEXT.
- IDLE:
  - start=1 → CAPTURE; clear sample_cnt, run_idx and both sticky flags.
  - start in any other state is ignored.
- CAPTURE:
  - Each sample_valid registers wr_en=1, wr_addr=sample_cnt, wr_data=sink on the next edge (latency 1). Then sample_cnt++.
  - On the write of address N-1 → KICK; sample_cnt wraps to 0.
  - wr_en is otherwise 0. wr_addr/wr_data hold their last value.
- KICK: fft_start=1 for exactly one cycle → FFT_WAIT.
- FFT_WAIT:
  - fft_done=1 → NEXT.
  - fft_done is sampled only here; a fft_done during KICK is ignored.
- NEXT:
  - If run_idx==RUNS-1 → done=1 for one cycle → IDLE; run_idx holds its final value.
  - Else run_idx++ → CAPTURE.
- Sample drop: sample_valid in KICK/FFT_WAIT/NEXT discards the sample and sets sample_drop. The sequence continues.
- abort: highest priority after reset. Any non-IDLE state → IDLE next cycle. No done, no fft_start. The write in flight on that edge is suppressed.
- Simultaneous start+abort in IDLE: abort wins, stays IDLE.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: FFT_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in FFT_WAIT, cleared on entry.
  - If FFT_TIMEOUT cycles elapse without fft_done: set timeout_err, go to IDLE, no done pulse.
  - fft_done on the same cycle the count expires wins; no error.
- Undefined: no counter; FFT_WAIT waits indefinitely; timeout_err is constant 0.

Test Plan (sim with FFT_DEPTH=3 → N=8, RUNS=3, SINK_WIDTH=14):
- Reset then idle: hold reset_n=0 for 3 clocks, then release → all outputs 0, busy=0. sample_valid pulses cause no wr_en.
- Full sequence: start, sample_valid every 3rd clk with sink=0..23, fft_done 10 clks after each fft_start →
  - 24 writes, addresses 0..7 three times, data 0..23.
  - 3 fft_start pulses; run_idx 0,1,2.
  - One done pulse; busy falls the cycle after done.
- Drop: sample_valid asserted during FFT_WAIT of run 0 → sample_drop=1, sticky. Run 1 still writes addr 0 with the next in-CAPTURE sample.
- Abort: abort asserted after 5 writes in run 1 → IDLE next cycle, no further wr_en/fft_start, done never pulses. A new start then restarts at run_idx=0, addr 0.
- Early fft_done: fft_done held 1 during KICK and dropped before FFT_WAIT → sequencer stays in FFT_WAIT until the next fft_done pulse.
- Timeout (FFT_TIMEOUT_EN, FFT_TIMEOUT=16): fft_done never asserted → timeout_err=1 exactly 16 clks after entering FFT_WAIT, busy=0, done=0. Undefined build: still busy after 100 clks.

Source files
------------

// File: rtl/fft_run_sequencer.sv
// Captures RUNS blocks of 2^FFT_DEPTH samples into the FFT buffer and kicks the FFT after each; writes land 1 cycle after sample_valid.
// No backpressure: samples outside CAPTURE are dropped (sticky flag); `define FFT_TIMEOUT_EN adds an FFT_WAIT watchdog.
module fft_run_sequencer #(
  parameter int SINK_WIDTH  = 14,
  parameter int FFT_DEPTH   = 11,
  parameter int RUNS        = 3,
  parameter int FFT_TIMEOUT = 65536
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        sample_valid,
  input  logic [SINK_WIDTH-1:0]       sink,
  output logic                        wr_en,
  output logic [FFT_DEPTH-1:0]        wr_addr,
  output logic [SINK_WIDTH-1:0]       wr_data,
  output logic                        fft_start,
  input  logic                        fft_done,
  output logic [$clog2(RUNS+1)-1:0]   run_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        sample_drop,
  output logic                        timeout_err
);

  localparam int RUN_W = $clog2(RUNS + 1);
  localparam logic [RUN_W-1:0]     LAST_RUN  = RUN_W'(RUNS - 1);
  localparam logic [FFT_DEPTH-1:0] LAST_ADDR = {FFT_DEPTH{1'b1}};

  if (RUNS < 1 || FFT_TIMEOUT < 1) begin : g_bad_param
    $error("fft_run_sequencer: RUNS and FFT_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    KICK,
    FFT_WAIT,
    NEXT
  } state_t;

  state_t               state;
  logic [FFT_DEPTH-1:0] sample_cnt;

`ifdef FFT_TIMEOUT_EN
  localparam int TMO_W = $clog2(FFT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FFT_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err_q;
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      fft_start   <= 1'b0;
      run_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_drop <= 1'b0;
`ifdef FFT_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      wr_en     <= 1'b0;
      fft_start <= 1'b0;
      done      <= 1'b0;

      // abort outranks everything, including the write a sample would make this edge
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state       <= CAPTURE;
              busy        <= 1'b1;
              sample_cnt  <= '0;
              run_idx     <= '0;
              sample_drop <= 1'b0;
`ifdef FFT_TIMEOUT_EN
              tmo_err_q   <= 1'b0;
`endif
            end
          end

          CAPTURE: begin
            if (sample_valid) begin
              wr_en      <= 1'b1;
              wr_addr    <= sample_cnt;
              wr_data    <= sink;
              sample_cnt <= sample_cnt + 1'b1;
              if (sample_cnt == LAST_ADDR) begin
                state     <= KICK;
                fft_start <= 1'b1;
              end
            end
          end

          KICK: begin
            state <= FFT_WAIT;
`ifdef FFT_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (sample_valid) sample_drop <= 1'b1;
          end

          FFT_WAIT: begin
            if (sample_valid) sample_drop <= 1'b1;
            // done is raised while in NEXT so busy drops one cycle after it
            if (fft_done) begin
              state <= NEXT;
              done  <= (run_idx == LAST_RUN);
            end
`ifdef FFT_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
              state     <= IDLE;
              busy      <= 1'b0;
              tmo_err_q <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end

          NEXT: begin
            if (sample_valid) sample_drop <= 1'b1;
            if (run_idx == LAST_RUN) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              run_idx <= run_idx + 1'b1;
              state   <= CAPTURE;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_run_sequencer.sv
// Directed bench for fft_run_sequencer with N=8, RUNS=3, FFT_TIMEOUT=16.
module tb_fft_run_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        sample_valid;
  logic [13:0] sink;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [13:0] wr_data;
  logic        fft_start;
  logic        fft_done;
  logic [1:0]  run_idx;
  logic        busy;
  logic        done;
  logic        sample_drop;
  logic        timeout_err;

  int nvec = 0;
  int nerr = 0;

  fft_run_sequencer #(
    .SINK_WIDTH (14),
    .FFT_DEPTH  (3),
    .RUNS       (3),
    .FFT_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .sample_valid(sample_valid),
    .sink        (sink),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .run_idx     (run_idx),
    .busy        (busy),
    .done        (done),
    .sample_drop (sample_drop),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample every 3rd clock; write and kick are checked at the edge after each strobe.
  task automatic capture_run(input int r, input int base, input int nsamp, input bit early);
    for (int i = 0; i < nsamp; i++) begin
      sample_valid = 1'b1;
      sink = 14'(base + i);
      tick();
      sample_valid = 1'b0;
      chk("cap_wr_en", wr_en, 1);
      chk("cap_wr_addr", wr_addr, i);
      chk("cap_wr_data", wr_data, base + i);
      chk("cap_run_idx", run_idx, r);
      chk("cap_fft_start", fft_start, (i == 7) ? 1 : 0);
      if (i == 7 && early) fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      chk("cap_gap_wr_en", wr_en, 0);
      if (i == 7) chk("kick_one_cycle", fft_start, 0);
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    sample_valid = 1'b0; sink = '0; fft_done = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_run_idx", run_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", sample_drop, 0);
    chk("rst_tmo", timeout_err, 0);

    // strobes in IDLE neither write nor count as drops
    sample_valid = 1'b1; sink = 14'd55;
    tick();
    sample_valid = 1'b0;
    chk("idle_wr_en", wr_en, 0);
    chk("idle_drop", sample_drop, 0);
    chk("idle_busy", busy, 0);

    // full three-run sequence with a dropped sample in run 0's FFT_WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_run_idx", run_idx, 0);
    capture_run(0, 0, 8, 1'b0);
    sample_valid = 1'b1; sink = 14'd99;
    tick();
    sample_valid = 1'b0;
    chk("drop_flag", sample_drop, 1);
    chk("drop_no_write", wr_en, 0);
    repeat (6) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("run0_no_done", done, 0);
    tick();
    chk("run1_idx", run_idx, 1);
    capture_run(1, 8, 8, 1'b0);
    repeat (7) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("run1_no_done", done, 0);
    tick();
    chk("run2_idx", run_idx, 2);
    capture_run(2, 16, 8, 1'b0);
    repeat (7) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("final_done", done, 1);
    chk("final_busy_with_done", busy, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("run_idx_holds", run_idx, 2);
    chk("drop_sticky", sample_drop, 1);

    // early fft_done during KICK must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_drop_clr", sample_drop, 0);
    capture_run(0, 40, 8, 1'b1);
    repeat (3) tick();
    chk("early_still_busy", busy, 1);
    chk("early_run_idx", run_idx, 0);
    chk("early_no_done", done, 0);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    tick();
    chk("early_advance", run_idx, 1);

    // abort after 5 writes in run 1, with a sample on the abort edge
    capture_run(1, 60, 5, 1'b0);
    abort = 1'b1; sample_valid = 1'b1; sink = 14'd77;
    tick();
    abort = 1'b0; sample_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_wr_suppressed", wr_en, 0);
    for (int k = 0; k < 4; k++) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk("post_abort_wr_en", wr_en, 0);
      chk("post_abort_kick", fft_start, 0);
      chk("post_abort_done", done, 0);
    end

    // start+abort together in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_run_idx", run_idx, 0);
    sample_valid = 1'b1; sink = 14'd5;
    tick();
    sample_valid = 1'b0;
    chk("restart_addr", wr_addr, 0);
    chk("restart_data", wr_data, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // FFT never completes
    start = 1'b1;
    tick();
    start = 1'b0;
    capture_run(0, 100, 8, 1'b0);
`ifdef FFT_TIMEOUT_EN
    repeat (14) tick();
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_busy_before", busy, 1);
    tick();
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_no_done", done, 0);
`else
    repeat (100) tick();
    chk("wait_still_busy", busy, 1);
    chk("wait_no_tmo", timeout_err, 0);
    chk("wait_no_done", done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wait_abort_busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
